scr1_pipe_wb_arb: RTL and testbench



---
 rtl/scr1_pipe_wb_arb.sv | 135 +++++++++++++
 tb/tb_scr1_pipe_wb_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_pipe_wb_arb.sv
// Write-back arbiter in front of the MPRF: merges ALU results with buffered
// load results into one registered write port and forwards in-flight values.
module scr1_pipe_wb_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int AW         = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_wb_req,
    input  logic [AW-1:0]   alu_wb_addr,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_vd,
    output logic            lsu_wb_rdy,
    input  logic [AW-1:0]   lsu_wb_addr,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            exu2mprf_w_req,
    output logic [AW-1:0]   exu2mprf_rd_addr,
    output logic [XLEN-1:0] exu2mprf_rd_data,
    input  logic [AW-1:0]   fwd_rs1_addr,
    input  logic [AW-1:0]   fwd_rs2_addr,
    output logic            fwd_rs1_hit,
    output logic            fwd_rs2_hit,
    output logic [XLEN-1:0] fwd_rs1_data,
    output logic [XLEN-1:0] fwd_rs2_data,
    output logic            wb_pending
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_DEPTH-1:0] live;
    logic [AW-1:0]         f_addr [FIFO_DEPTH];
    logic [XLEN-1:0]       f_data [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic                  alu_take;
    logic                  push;
    logic                  empty;
    logic                  head_live;
    logic                  pop;
    logic                  load_head;
    logic [FIFO_DEPTH-1:0] kill;

    assign lsu_wb_rdy = (count < CW'(FIFO_DEPTH));
    assign alu_take   = alu_wb_req && (alu_wb_addr != '0);
    assign push       = lsu_wb_vd && lsu_wb_rdy && (lsu_wb_addr != '0);
    assign empty      = (count == '0);

    always_comb begin
        kill = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            kill[i] = alu_take && live[i] && (f_addr[i] == alu_wb_addr);
        end
    end

    // A killed or dead head is always dropped; a live head only leaves when the ALU is idle.
    assign head_live = !empty && live[rd_ptr] && !kill[rd_ptr];
    assign load_head = head_live && !alu_take;
    assign pop       = !empty && !(head_live && alu_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_addr[i] <= '0;
                f_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (kill[i]) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            // Push slot is never the head when both happen, and the push is younger than any kill.
            if (push) begin
                live[wr_ptr]   <= 1'b1;
                f_addr[wr_ptr] <= lsu_wb_addr;
                f_data[wr_ptr] <= lsu_wb_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu2mprf_w_req   <= 1'b0;
            exu2mprf_rd_addr <= '0;
            exu2mprf_rd_data <= '0;
        end else if (alu_take) begin
            exu2mprf_w_req   <= 1'b1;
            exu2mprf_rd_addr <= alu_wb_addr;
            exu2mprf_rd_data <= alu_wb_data;
        end else if (load_head) begin
            exu2mprf_w_req   <= 1'b1;
            exu2mprf_rd_addr <= f_addr[rd_ptr];
            exu2mprf_rd_data <= f_data[rd_ptr];
        end else begin
            exu2mprf_w_req   <= 1'b0;
        end
    end

    // Scan oldest to youngest so the youngest matching live entry wins.
    function automatic logic [XLEN:0] fwd_lookup(input logic [AW-1:0] rs);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        if (exu2mprf_w_req && (exu2mprf_rd_addr == rs)) begin
            res = {1'b1, exu2mprf_rd_data};
        end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (live[idx] && (f_addr[idx] == rs)) begin
                res = {1'b1, f_data[idx]};
            end
        end
        if (rs == '0) res = '0;
        return res;
    endfunction

    always_comb begin
        {fwd_rs1_hit, fwd_rs1_data} = fwd_lookup(fwd_rs1_addr);
        {fwd_rs2_hit, fwd_rs2_data} = fwd_lookup(fwd_rs2_addr);
    end

    assign wb_pending = (|live) || exu2mprf_w_req;

endmodule

// File: tb/tb_scr1_pipe_wb_arb.sv
// Randomized bench for scr1_pipe_wb_arb against a queue-based reference model.
module tb_scr1_pipe_wb_arb;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wb_req = 1'b0;
    logic [4:0]  alu_wb_addr = '0;
    logic [31:0] alu_wb_data = '0;
    logic        lsu_wb_vd = 1'b0;
    logic        lsu_wb_rdy;
    logic [4:0]  lsu_wb_addr = '0;
    logic [31:0] lsu_wb_data = '0;
    logic        exu2mprf_w_req;
    logic [4:0]  exu2mprf_rd_addr;
    logic [31:0] exu2mprf_rd_data;
    logic [4:0]  fwd_rs1_addr = '0;
    logic [4:0]  fwd_rs2_addr = '0;
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_rs1_data;
    logic [31:0] fwd_rs2_data;
    logic        wb_pending;

    scr1_pipe_wb_arb #(.FIFO_DEPTH(D), .XLEN(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_req(alu_wb_req), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .lsu_wb_vd(lsu_wb_vd), .lsu_wb_rdy(lsu_wb_rdy),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .exu2mprf_w_req(exu2mprf_w_req), .exu2mprf_rd_addr(exu2mprf_rd_addr),
        .exu2mprf_rd_data(exu2mprf_rd_data),
        .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
        .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [36:0] exp_q[$];
    logic        m_req;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        m_req = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic fwd_exp(input logic [4:0] rs, output logic hit, output logic [31:0] data);
        hit = 1'b0;
        data = '0;
        if (rs != 0) begin
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].live && q[i].addr == rs) begin
                    hit = 1'b1;
                    data = q[i].data;
                end
            end
            if (!hit && m_req && m_addr == rs) begin
                hit = 1'b1;
                data = m_data;
            end
        end
    endtask

    task automatic check_outputs();
        logic        h;
        logic [31:0] d;
        logic        pend;
        logic [36:0] w;
        pend = m_req;
        foreach (q[i]) if (q[i].live) pend = 1'b1;
        check("rdy", 32'(lsu_wb_rdy), 32'(q.size() < D));
        check("pending", 32'(wb_pending), 32'(pend));
        check("w_req", 32'(exu2mprf_w_req), 32'(m_req));
        check("rd_addr", 32'(exu2mprf_rd_addr), 32'(m_addr));
        check("rd_data", exu2mprf_rd_data, m_data);
        if (m_req) begin
            if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
            else begin
                w = exp_q.pop_front();
                check("wr_stream", {27'd0, exu2mprf_rd_addr} ^ exu2mprf_rd_data, {27'd0, w[36:32]} ^ w[31:0]);
            end
        end
        fwd_exp(fwd_rs1_addr, h, d);
        check("rs1_hit", 32'(fwd_rs1_hit), 32'(h));
        if (h) check("rs1_data", fwd_rs1_data, d);
        fwd_exp(fwd_rs2_addr, h, d);
        check("rs2_hit", 32'(fwd_rs2_hit), 32'(h));
        if (h) check("rs2_data", fwd_rs2_data, d);
    endtask

    // One clock: check current outputs, then drive inputs and advance the model.
    task automatic cycle(input logic a_req, input logic [4:0] a_addr, input logic [31:0] a_data,
                         input logic vd, input logic [4:0] l_addr, input logic [31:0] l_data,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic take;
        logic push;
        logic got;
        ent_t h;
        ent_t n;
        @(negedge clk);
        fwd_rs1_addr = r1;
        fwd_rs2_addr = r2;
        #1;
        check_outputs();
        alu_wb_req = a_req; alu_wb_addr = a_addr; alu_wb_data = a_data;
        lsu_wb_vd = vd; lsu_wb_addr = l_addr; lsu_wb_data = l_data;
        take = a_req && a_addr != 0;
        push = vd && (q.size() < D) && l_addr != 0;
        for (int i = 0; i < q.size(); i++) if (take && q[i].addr == a_addr) q[i].live = 1'b0;
        got = 1'b0;
        if (q.size() > 0) begin
            if (!q[0].live) void'(q.pop_front());
            else if (!take) begin
                h = q.pop_front();
                got = 1'b1;
            end
        end
        if (take) begin
            m_req = 1'b1; m_addr = a_addr; m_data = a_data;
        end else if (got) begin
            m_req = 1'b1; m_addr = h.addr; m_data = h.data;
        end else m_req = 1'b0;
        if (m_req) exp_q.push_back({m_addr, m_data});
        if (push) begin
            n.live = 1'b1; n.addr = l_addr; n.data = l_data;
            q.push_back(n);
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    task automatic check_reset_values();
        check("rst_w_req", 32'(exu2mprf_w_req), 32'd0);
        check("rst_addr", 32'(exu2mprf_rd_addr), 32'd0);
        check("rst_data", exu2mprf_rd_data, 32'd0);
        check("rst_rdy", 32'(lsu_wb_rdy), 32'd1);
        check("rst_hit1", 32'(fwd_rs1_hit), 32'd0);
        check("rst_hit2", 32'(fwd_rs2_hit), 32'd0);
        check("rst_pend", 32'(wb_pending), 32'd0);
    endtask

    initial begin
        int alu_pct;
        int vd_pct;
        model_reset();
        fwd_rs1_addr = 5'd3;
        fwd_rs2_addr = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only
        cycle(1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        check("alu_data", exu2mprf_rd_data, 32'hA5A5_0001);
        check("alu_fwd", fwd_rs1_data, 32'hA5A5_0001);
        idle(5'd0, 5'd0);
        check("alu_done", 32'(exu2mprf_w_req), 32'd0);

        // Load path
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd0);
        idle(5'd7, 5'd0);
        check("ld_pend2", 32'(wb_pending), 32'd1);
        idle(5'd7, 5'd0);
        check("ld_data", exu2mprf_rd_data, 32'h1234);
        idle(5'd0, 5'd0);

        // Contention and back-pressure; a third load is offered until accepted
        cycle(1'b1, 5'd1, 32'h10, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
        cycle(1'b1, 5'd2, 32'h20, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h55, 5'd3, 5'd4);
        check("bp_rdy", 32'(lsu_wb_rdy), 32'd0);
        cycle(1'b1, 5'd2, 32'h21, 1'b1, 5'd5, 32'h55, 5'd3, 5'd4);
        repeat (6) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55, 5'd3, 5'd5);
        repeat (3) idle(5'd0, 5'd0);

        // Kill of a buffered stale load
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11, 5'd9, 5'd0);
        cycle(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        check("kill_fwd", fwd_rs1_data, 32'h22);
        repeat (3) idle(5'd9, 5'd0);

        // Forwarding priority: FIFO entry beats the output register
        cycle(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2, 5'd6, 5'd0);
        cycle(1'b1, 5'd1, 32'h7, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
        check("prio_data", fwd_rs1_data, 32'h2);
        check("prio_rs2", 32'(fwd_rs2_hit), 32'd0);
        repeat (3) idle(5'd6, 5'd0);

        // Randomized traffic with phase-varying ALU pressure
        for (int blk = 0; blk < 16; blk++) begin
            alu_pct = $urandom_range(0, 100);
            vd_pct = $urandom_range(20, 90);
            for (int c = 0; c < 40; c++) begin
                cycle($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 99) < vd_pct, 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        repeat (4) idle(5'd0, 5'd0);

        // Reset mid-operation with two live entries and a pending write
        cycle(1'b1, 5'd1, 32'h10, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
        cycle(1'b1, 5'd2, 32'h20, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
        cycle(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        @(negedge clk);
        #1;
        check("pre_rst_q", 32'(q.size()), 32'd2);
        check("pre_rst_req", 32'(exu2mprf_w_req), 32'd1);
        alu_wb_req = 1'b0;
        lsu_wb_vd = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle(5'd3, 5'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
